// File: rtl/jacobi_iter_sequencer.sv
// Iteration controller for the Jacobi solver: runs the matrix-by-vector unit for N passes and
// feeds each result back as the next operand. Optional early exit on a fixed point: JACOBI_EARLY_EXIT_EN.
module jacobi_iter_sequencer #(
    parameter int NO_OF_EQN      = 10,
    parameter int ELEMENT_WIDTH  = 32,
    parameter int ITER_W         = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 go,
    input  logic [ITER_W-1:0]                    iter_count,
    input  logic [NO_OF_EQN*ELEMENT_WIDTH-1:0]   init_vector,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 error,
    output logic [ITER_W-1:0]                    iter_done,
    output logic [NO_OF_EQN*ELEMENT_WIDTH-1:0]   result_vector,
    output logic                                 mvm_start,
    output logic [NO_OF_EQN*ELEMENT_WIDTH-1:0]   mvm_vector,
    input  logic                                 mvm_finish,
    input  logic [NO_OF_EQN*ELEMENT_WIDTH-1:0]   mvm_result
`ifdef JACOBI_EARLY_EXIT_EN
    ,
    output logic                                 converged
`endif
);

    // state   | meaning
    // IDLE    | waiting for go
    // RUN     | start high, waiting for finish or watchdog expiry
    // CAPTURE | latch product, count the pass
    // GAP     | start low for one cycle so the unit re-arms
    // DONE    | one-cycle completion pulse
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_CAPTURE, S_GAP, S_DONE} state_t;

    localparam int VEC_W = NO_OF_EQN * ELEMENT_WIDTH;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);

    state_t               state, state_nxt;
    logic [VEC_W-1:0]     vec_reg;
    logic [ITER_W-1:0]    target;
    logic [ITER_W-1:0]    iter_done_r;
    logic [ITER_W-1:0]    iter_inc;
    logic [WD_W-1:0]      wd;
    logic                 error_r;
    logic                 load_init;
    logic                 capture;
    logic                 set_err;
    logic                 conv_hit;

`ifdef JACOBI_EARLY_EXIT_EN
    logic converged_r;
    assign conv_hit  = (mvm_result == vec_reg);
    assign converged = converged_r;
`else
    assign conv_hit  = 1'b0;
`endif

    assign iter_inc = iter_done_r + ITER_W'(1);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_init = 1'b0;
        capture   = 1'b0;
        set_err   = 1'b0;
        case (state)
            S_IDLE: begin
                if (go) begin
                    load_init = 1'b1;
                    state_nxt = (iter_count == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                // finish wins over a timeout landing on the same cycle
                if (mvm_finish) begin
                    state_nxt = S_CAPTURE;
                end else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    set_err   = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_CAPTURE: begin
                capture   = 1'b1;
                state_nxt = ((iter_inc == target) || conv_hit) ? S_DONE : S_GAP;
            end
            S_GAP:   state_nxt = S_RUN;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Registered start so the unit never sees a combinational path from our inputs.
    always_ff @(posedge clk) begin
        if (reset) mvm_start <= 1'b0;
        else       mvm_start <= (state_nxt == S_RUN) || (state_nxt == S_CAPTURE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vec_reg     <= '0;
            target      <= '0;
            iter_done_r <= '0;
            error_r     <= 1'b0;
            wd          <= '0;
        end else begin
            if (load_init) begin
                vec_reg     <= init_vector;
                target      <= iter_count;
                iter_done_r <= '0;
                error_r     <= 1'b0;
            end
            if (capture) begin
                vec_reg     <= mvm_result;
                iter_done_r <= iter_inc;
            end
            if (set_err) error_r <= 1'b1;
            if (load_init || state == S_GAP) wd <= '0;
            else if (state == S_RUN)         wd <= wd + WD_W'(1);
        end
    end

`ifdef JACOBI_EARLY_EXIT_EN
    always_ff @(posedge clk) begin
        if (reset)                    converged_r <= 1'b0;
        else if (load_init)           converged_r <= 1'b0;
        else if (capture && conv_hit) converged_r <= 1'b1;
    end
`endif

    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);
    assign error         = error_r;
    assign iter_done     = iter_done_r;
    assign result_vector = vec_reg;
    assign mvm_vector    = vec_reg;

endmodule
